// File: rtl/piso_stream_pkg.sv
// ============================================================================
// piso_stream_pkg: state encoding and count-width helper shared by serializers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package piso_stream_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } piso_state_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_slice_mux.sv
// ============================================================================
// piso_slice_mux: picks the output-end slice of the shift register, zero when idle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_slice_mux #(
  parameter int DATA_OUT_WIDTH = 16,
  parameter int LSB_FIRST      = 1
) (
  input  logic [DATA_OUT_WIDTH-1:0] lo_slice,
  input  logic [DATA_OUT_WIDTH-1:0] hi_slice,
  input  logic                      valid,
  output logic [DATA_OUT_WIDTH-1:0] data_out
);

  logic [DATA_OUT_WIDTH-1:0] slice;

  assign slice    = (LSB_FIRST != 0) ? lo_slice : hi_slice;
  assign data_out = valid ? slice : '0;

endmodule

`default_nettype wire

// File: rtl/piso_stream.sv
// ============================================================================
// piso_stream: parallel-in serial-out streamer with a one-word holding buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int LSB_FIRST      = 1,
  localparam int NUM_WORDS     = DATA_IN_WIDTH / DATA_OUT_WIDTH,
  localparam int CW            = count_width(NUM_WORDS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  input  logic [CW-1:0]             in_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      out_last,
  output logic                      busy
);

  if ((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0 || NUM_WORDS < 2) begin : g_bad_params
    $fatal(1, "piso_stream: DATA_IN_WIDTH must be a multiple (>=2x) of DATA_OUT_WIDTH");
  end

  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_WORDS);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  piso_state_t              state, state_n;
  logic [DATA_IN_WIDTH-1:0] sr, sr_n, hb, hb_n, sr_shift;
  logic [CW-1:0]            rem, rem_n, hb_cnt, hb_cnt_n, in_eff;
  logic                     hb_valid, in_fire, out_fire, is_last, last_fire;

  assign hb_valid  = (state == ST_FULL);
  assign in_ready  = !hb_valid;
  assign out_valid = (rem != '0);
  assign out_last  = (rem == ONE_CNT);
  assign busy      = out_valid || hb_valid;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign is_last   = (rem == ONE_CNT);
  assign last_fire = out_fire && is_last;

  // A zero or oversized count means "the whole word".
  assign in_eff   = (in_count == '0 || in_count > FULL_CNT) ? FULL_CNT : in_count;
  assign sr_shift = (LSB_FIRST != 0) ? (sr >> DATA_OUT_WIDTH) : (sr << DATA_OUT_WIDTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_EMPTY;
      sr     <= '0;
      rem    <= '0;
      hb     <= '0;
      hb_cnt <= '0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      rem    <= rem_n;
      hb     <= hb_n;
      hb_cnt <= hb_cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    rem_n    = rem;
    hb_n     = hb;
    hb_cnt_n = hb_cnt;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          sr_n    = data_in;
          rem_n   = in_eff;
          state_n = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (out_fire && !is_last) begin
          sr_n  = sr_shift;
          rem_n = rem - ONE_CNT;
        end
        if (last_fire) begin
          // Reloading straight from the input keeps back-to-back words gapless.
          if (in_fire) begin
            sr_n  = data_in;
            rem_n = in_eff;
          end else begin
            sr_n    = '0;
            rem_n   = '0;
            state_n = ST_EMPTY;
          end
        end else if (in_fire) begin
          hb_n     = data_in;
          hb_cnt_n = in_eff;
          state_n  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          if (is_last) begin
            sr_n     = hb;
            rem_n    = hb_cnt;
            hb_n     = '0;
            hb_cnt_n = '0;
            state_n  = ST_ACTIVE;
          end else begin
            sr_n  = sr_shift;
            rem_n = rem - ONE_CNT;
          end
        end
      end
      default: begin
        state_n = ST_EMPTY;
      end
    endcase
  end

  piso_slice_mux #(
    .DATA_OUT_WIDTH (DATA_OUT_WIDTH),
    .LSB_FIRST      (LSB_FIRST)
  ) u_slice_mux (
    .lo_slice (sr[DATA_OUT_WIDTH-1:0]),
    .hi_slice (sr[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH]),
    .valid    (out_valid),
    .data_out (data_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_piso_stream.sv
// ============================================================================
// tb_piso_stream: directed checks of piso_stream, LSB-first and MSB-first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_piso_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_last, a_busy;
  logic [63:0] a_data_in = '0;
  logic [2:0]  a_in_count = '0;
  logic [15:0] a_data_out;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last, b_busy;
  logic [63:0] b_data_in = '0;
  logic [2:0]  b_in_count = '0;
  logic [15:0] b_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_stream #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16), .LSB_FIRST(1)) u_dut_lsb (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in), .in_count(a_in_count),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
    .out_last(a_out_last), .busy(a_busy)
  );

  piso_stream #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16), .LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in), .in_count(b_in_count),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
    .out_last(b_out_last), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic beat_a(input string tag, input logic [15:0] d, input logic last);
    check({tag, ".valid"}, 64'(a_out_valid), 64'(1'b1));
    check({tag, ".data"},  64'(a_data_out),  64'(d));
    check({tag, ".last"},  64'(a_out_last),  64'(last));
  endtask

  task automatic idle_a(input string tag);
    check({tag, ".valid"}, 64'(a_out_valid), 64'(1'b0));
    check({tag, ".data"},  64'(a_data_out),  64'h0);
    check({tag, ".last"},  64'(a_out_last),  64'(1'b0));
    check({tag, ".busy"},  64'(a_busy),      64'(1'b0));
    check({tag, ".rdy"},   64'(a_in_ready),  64'(1'b1));
  endtask

  initial begin
    logic [15:0] exp_bb [8];
    exp_bb = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};

    // Reset state
    step();
    step();
    idle_a("rst");
    check("rst.b_valid", 64'(b_out_valid), 64'(1'b0));
    check("rst.b_rdy",   64'(b_in_ready),  64'(1'b1));
    reset = 1'b0;

    // Full word, count 0 -> all four slices, LSB first
    a_in_valid = 1'b1; a_data_in = 64'h4444_3333_2222_1111; a_in_count = 3'd0; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    beat_a("w1.b0", 16'h1111, 1'b0);
    step(); beat_a("w1.b1", 16'h2222, 1'b0);
    step(); beat_a("w1.b2", 16'h3333, 1'b0);
    step(); beat_a("w1.b3", 16'h4444, 1'b1);
    step(); idle_a("w1.end");

    // Back-to-back words: eight gapless beats
    a_in_valid = 1'b1; a_data_in = 64'h0004_0003_0002_0001;
    step();
    a_data_in = 64'h0008_0007_0006_0005;
    check("bb.rdy_a", 64'(a_in_ready), 64'(1'b1));
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        a_in_valid = 1'b0;
        check("bb.rdy_full", 64'(a_in_ready), 64'(1'b0));
      end
      beat_a($sformatf("bb.b%0d", i), exp_bb[i], (i == 3 || i == 7));
      if (i == 4) check("bb.rdy_b", 64'(a_in_ready), 64'(1'b1));
      step();
    end
    idle_a("bb.end");

    // MSB first, partial word of two beats
    b_in_valid = 1'b1; b_data_in = 64'hAAAA_BBBB_CCCC_DDDD; b_in_count = 3'd2; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    check("msb.b0.data", 64'(b_data_out), 64'hAAAA);
    check("msb.b0.last", 64'(b_out_last), 64'(1'b0));
    step();
    check("msb.b1.data", 64'(b_data_out), 64'hBBBB);
    check("msb.b1.last", 64'(b_out_last), 64'(1'b1));
    step();
    check("msb.end.valid", 64'(b_out_valid), 64'(1'b0));
    check("msb.end.data",  64'(b_data_out),  64'h0);

    // Backpressure mid-word with a second word offered
    a_in_valid = 1'b1; a_data_in = 64'h000C_000B_000A_0009; a_in_count = 3'd4;
    step();
    a_in_valid = 1'b0;
    beat_a("st.b0", 16'h0009, 1'b0);
    step();
    beat_a("st.b1", 16'h000A, 1'b0);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_data_in = 64'h0010_000F_000E_000D;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_a($sformatf("st.hold%0d", i), 16'h000A, 1'b0);
      check($sformatf("st.hold%0d.rdy", i), 64'(a_in_ready), 64'(1'b0));
      check($sformatf("st.hold%0d.busy", i), 64'(a_busy), 64'(1'b1));
      if (i < 2) step();
    end
    a_out_ready = 1'b1;
    step(); beat_a("st.b2", 16'h000B, 1'b0);
    step(); beat_a("st.b3", 16'h000C, 1'b1);
    check("st.b3.rdy", 64'(a_in_ready), 64'(1'b0));
    step(); beat_a("st.d0", 16'h000D, 1'b0);
    check("st.d0.rdy", 64'(a_in_ready), 64'(1'b1));
    step(); beat_a("st.d1", 16'h000E, 1'b0);
    step(); beat_a("st.d2", 16'h000F, 1'b0);
    step(); beat_a("st.d3", 16'h0010, 1'b1);
    step(); idle_a("st.end");

    // Reset mid-word with the holding buffer full
    a_in_valid = 1'b1; a_data_in = 64'h0014_0013_0012_0011;
    step();
    a_data_in = 64'h0018_0017_0016_0015;
    beat_a("rw.b0", 16'h0011, 1'b0);
    step();
    a_in_valid = 1'b0;
    beat_a("rw.b1", 16'h0012, 1'b0);
    check("rw.full", 64'(a_in_ready), 64'(1'b0));
    step();
    reset = 1'b1;
    #1;
    idle_a("rw.rst");
    step();
    reset = 1'b0;
    step();
    step();
    idle_a("rw.post");

    // Fresh partial word after reset: three beats
    a_in_valid = 1'b1; a_data_in = 64'h0018_0017_0016_0015; a_in_count = 3'd3;
    step();
    a_in_valid = 1'b0;
    beat_a("pw.b0", 16'h0015, 1'b0);
    step(); beat_a("pw.b1", 16'h0016, 1'b0);
    step(); beat_a("pw.b2", 16'h0017, 1'b1);
    step(); idle_a("pw.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 64, parallel input word width in bits.
REQ-002 Parameter DATA_OUT_WIDTH, default 16, serial beat width in bits; DATA_IN_WIDTH SHALL be an integer multiple of DATA_OUT_WIDTH, ratio NUM_WORDS >= 2.
REQ-003 Parameter LSB_FIRST, default 1, 1 = lowest slice emitted first, 0 = highest slice first.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 IN_VALID  input  1  DATA_IN/IN_COUNT valid.
REQ-007 IN_READY  output  1  block accepts a word this cycle.
REQ-008 DATA_IN  input  DATA_IN_WIDTH  parallel word.
REQ-009 IN_COUNT  input  CW=clog2(NUM_WORDS+1)  number of beats to emit from this word; 0 or >NUM_WORDS means NUM_WORDS.
REQ-010 OUT_VALID  output  1  DATA_OUT valid.
REQ-011 OUT_READY  input  1  downstream accepts beat.
REQ-012 DATA_OUT  output  DATA_OUT_WIDTH  current serial beat.
REQ-013 OUT_LAST  output  1  current beat is the final beat of its word.
REQ-014 BUSY  output  1  OUT_VALID or a word held pending.

Function
REQ-015 Input transfer on IN_VALID && IN_READY; output transfer on OUT_VALID && OUT_READY.
REQ-016 Two stages: shift register (SR, beats remaining counter REM) and one-word holding buffer (HB, with its effective count).
REQ-017 States: EMPTY (SR and HB empty), ACTIVE (SR non-empty, HB empty), FULL (SR and HB non-empty).
REQ-018 IN_READY = !HB_valid; combinational from registered state only, never from IN_VALID or OUT_READY.
REQ-019 EMPTY + input transfer -> word loads directly into SR, REM = effective count, ACTIVE next cycle; first beat on DATA_OUT one cycle after acceptance.
REQ-020 ACTIVE + input transfer without final-beat output transfer -> word goes to HB, FULL.
REQ-021 Output transfer with REM > 1 -> SR shifts one DATA_OUT_WIDTH slice toward the output end (zero fill), REM decrements.
REQ-022 Output transfer with REM == 1 (OUT_LAST): if HB valid, HB moves to SR same edge, HB clears, FULL->ACTIVE; else if input transfer same cycle, DATA_IN loads SR, stays ACTIVE; else EMPTY.
REQ-023 Sustained IN_VALID and OUT_READY SHALL give one beat per cycle with no bubble between words.
REQ-024 OUT_VALID = (REM != 0); OUT_LAST = (REM == 1).
REQ-025 DATA_OUT = SR[DATA_OUT_WIDTH-1:0] when LSB_FIRST=1, SR[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH] when 0; SHALL be all-zero when OUT_VALID=0.
REQ-026 OUT_READY low SHALL hold SR, REM, DATA_OUT, OUT_LAST stable.
REQ-027 Partial word (IN_COUNT=k) SHALL emit exactly the first k slices in the selected order, then OUT_LAST.
REQ-028 IN_VALID with IN_READY low SHALL have no effect.
REQ-029 BUSY = OUT_VALID || HB_valid.

Reset
REQ-030 RESET asserted SHALL immediately clear SR, HB, REM, HB_valid; outputs: OUT_VALID=0, OUT_LAST=0, DATA_OUT=0, BUSY=0, IN_READY=1.
REQ-031 Reset mid-word SHALL discard all remaining beats and any held word; no beat emitted after deassertion until a new input transfer.
REQ-032 First input transfer accepted on first rising edge after RESET deasserts.

Structure
REQ-033 Shared package SHALL hold the state encoding (EMPTY/ACTIVE/FULL) and a clog2-based count-width function reused by other dnnweaver serializers.
REQ-034 Optional sub-module piso_slice_mux selects output slice per LSB_FIRST; no other hierarchy.
REQ-035 Parameter legality (divisibility, NUM_WORDS>=2) SHALL be checked at elaboration with a fatal error.

Verification (64/16, NUM_WORDS=4)
REQ-036 LSB_FIRST=1, DATA_IN=0x4444_3333_2222_1111, IN_COUNT=0, OUT_READY=1 -> beats 0x1111,0x2222,0x3333,0x4444, OUT_LAST on 4th only, first beat 1 cycle after accept.
REQ-037 Back-to-back words A then B, IN_VALID and OUT_READY held high -> 8 consecutive valid beats, no gap, IN_READY high throughout except while HB is full.
REQ-038 LSB_FIRST=0, IN_COUNT=2, DATA_IN=0xAAAA_BBBB_CCCC_DDDD -> beats 0xAAAA,0xBBBB, OUT_LAST on 2nd, then OUT_VALID=0.
REQ-039 OUT_READY low 3 cycles mid-word with second word offered -> DATA_OUT stable, second word to HB, IN_READY=0 until final beat of first word transfers.
REQ-040 RESET pulse after 2nd beat of a word with HB full -> all outputs zero, IN_READY=1, no further beats; next word serialises normally.
